// File: rtl/otter_pkg.sv
// Shared encodings for the OTTER RV32I core: opcodes, funct3 codes, ALU ops, CSR map.
package otter_pkg;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   localparam logic [2:0] F3_B    = 3'b000;
   localparam logic [2:0] F3_H    = 3'b001;
   localparam logic [2:0] F3_W    = 3'b010;
   localparam logic [2:0] F3_BU   = 3'b100;
   localparam logic [2:0] F3_HU   = 3'b101;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_PRIV = 3'b000;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam int          MCAUSE_INTR_BIT = 31;
   localparam logic [31:0] INSN_MRET   = 32'h30200073;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
      alu_decode = ALU_ADD;
      case (f3)
         3'b000:  alu_decode = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_decode = ALU_SLL;
         3'b010:  alu_decode = ALU_SLT;
         3'b011:  alu_decode = ALU_SLTU;
         3'b100:  alu_decode = ALU_XOR;
         3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_decode = ALU_OR;
         default: alu_decode = ALU_AND;
      endcase
   endfunction

   function automatic logic [4:0] lowest_set(input logic [31:0] v);
      lowest_set = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) lowest_set = 5'(i);
      end
   endfunction
endpackage

// File: rtl/otter_alu.sv
// OTTER integer ALU: combinational 32-bit result for the RV32I arithmetic/logic ops.
module otter_alu
   import otter_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  alu_op_e     i_op,
   output logic [31:0] o_result
);
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;

   assign a_s = i_a;
   assign b_s = i_b;

   always_comb begin
      o_result = '0;
      case (i_op)
         ALU_ADD:  o_result = i_a + i_b;
         ALU_SUB:  o_result = i_a - i_b;
         ALU_SLL:  o_result = i_a << i_b[4:0];
         ALU_SLT:  o_result = {31'b0, a_s < b_s};
         ALU_SLTU: o_result = {31'b0, i_a < i_b};
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_SRL:  o_result = i_a >> i_b[4:0];
         ALU_SRA:  o_result = a_s >>> i_b[4:0];
         ALU_OR:   o_result = i_a | i_b;
         default:  o_result = i_a & i_b;
      endcase
   end
endmodule

// File: rtl/otter_mcu_core.sv
// Single-cycle RV32I OTTER core with machine-mode CSRs and level interrupts.
// Define OTTER_RVFI_EN to add the rvfi_* retirement trace ports.
module otter_mcu_core
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = 32'h0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_intrpt,
   input  logic [31:0] i_imem_r_data,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_dmem_r_data,
   output logic        o_dmem_re,
   output logic        o_dmem_we,
   output logic [3:0]  o_dmem_sel,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_w_data
`ifdef OTTER_RVFI_EN
   ,
   output logic        rvfi_valid,
   output logic [31:0] rvfi_insn,
   output logic [31:0] rvfi_pc_rdata,
   output logic [31:0] rvfi_pc_wdata,
   output logic [4:0]  rvfi_rd_addr,
   output logic [31:0] rvfi_rd_wdata,
   output logic [31:0] rvfi_mem_addr,
   output logic [3:0]  rvfi_mem_rmask,
   output logic [3:0]  rvfi_mem_wmask,
   output logic [31:0] rvfi_mem_wdata
`endif
);
   logic [31:0] insn, pc_q, pc_d, pc_plus4;
   logic [31:0] rf_q [1:31];
   logic [6:0]  opcode, f7;
   logic [4:0]  rd_a, rs1_a, rs2_a, irq_num;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_v, rs2_v, ea;
   logic signed [31:0] rs1_s, rs2_s;
   logic [31:0] alu_a, alu_b, alu_res, ld_val, st_data, csr_rdata, csr_src, csr_wdata;
   alu_op_e     alu_op;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [3:0]  lane_sel;
   logic        rd_we, dmem_re, dmem_we, br_take, irq_take, legal_imm, legal_reg;
   logic [31:0] rd_val;
   logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
   logic [31:0] csr_mie_q, csr_mie_d, mcause_q, mcause_d;
   logic [29:0] mtvec_q, mtvec_d, mepc_q, mepc_d;

   assign insn     = i_imem_r_data;
   assign opcode   = insn[6:0];
   assign rd_a     = insn[11:7];
   assign f3       = insn[14:12];
   assign rs1_a    = insn[19:15];
   assign rs2_a    = insn[24:20];
   assign f7       = insn[31:25];
   assign imm_i    = {{20{insn[31]}}, insn[31:20]};
   assign imm_s    = {{20{insn[31]}}, insn[31:25], insn[11:7]};
   assign imm_b    = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
   assign imm_u    = {insn[31:12], 12'b0};
   assign imm_j    = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
   assign rs1_v    = (rs1_a == 5'd0) ? 32'd0 : rf_q[rs1_a];
   assign rs2_v    = (rs2_a == 5'd0) ? 32'd0 : rf_q[rs2_a];
   assign rs1_s    = rs1_v;
   assign rs2_s    = rs2_v;
   assign pc_plus4 = pc_q + 32'd4;
   assign ea       = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign irq_take = mstatus_mie_q & (|(i_intrpt & csr_mie_q));
   assign irq_num  = lowest_set(i_intrpt & csr_mie_q);
   assign legal_imm = (f3 == F3_SLL) ? (f7 == 7'h00) :
                      (f3 == F3_SR)  ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
   assign legal_reg = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == F3_SR));

   always_comb begin
      alu_a  = rs1_v;
      alu_b  = rs2_v;
      alu_op = ALU_ADD;
      case (opcode)
         OP_LUI:   begin alu_a = 32'd0; alu_b = imm_u; end
         OP_AUIPC: begin alu_a = pc_q;  alu_b = imm_u; end
         OP_IMM:   begin alu_b = imm_i; alu_op = alu_decode(f3, (f3 == F3_SR) & insn[30]); end
         OP_REG:   alu_op = alu_decode(f3, insn[30]);
         default:  ;
      endcase
   end

   otter_alu u_alu (.i_a(alu_a), .i_b(alu_b), .i_op(alu_op), .o_result(alu_res));

   // Byte-lane steering: the memory returns and accepts whole aligned words
   always_comb begin
      case (ea[1:0])
         2'd0:    ld_byte = i_dmem_r_data[7:0];
         2'd1:    ld_byte = i_dmem_r_data[15:8];
         2'd2:    ld_byte = i_dmem_r_data[23:16];
         default: ld_byte = i_dmem_r_data[31:24];
      endcase
      ld_half = ea[1] ? i_dmem_r_data[31:16] : i_dmem_r_data[15:0];
      case (f3[1:0])
         2'b00: begin lane_sel = 4'b0001 << ea[1:0]; st_data = {24'b0, rs2_v[7:0]} << {ea[1:0], 3'b000}; end
         2'b01: begin lane_sel = ea[1] ? 4'b1100 : 4'b0011; st_data = {16'b0, rs2_v[15:0]} << {ea[1], 4'b0000}; end
         default: begin lane_sel = 4'b1111; st_data = rs2_v; end
      endcase
      case (f3)
         F3_B:    ld_val = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_val = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_val = {24'b0, ld_byte};
         F3_HU:   ld_val = {16'b0, ld_half};
         default: ld_val = i_dmem_r_data;
      endcase
      case (f3)
         F3_BEQ:  br_take = rs1_v == rs2_v;
         F3_BNE:  br_take = rs1_v != rs2_v;
         F3_BLT:  br_take = rs1_s < rs2_s;
         F3_BGE:  br_take = rs1_s >= rs2_s;
         F3_BLTU: br_take = rs1_v < rs2_v;
         F3_BGEU: br_take = rs1_v >= rs2_v;
         default: br_take = 1'b0;
      endcase
   end

   always_comb begin
      csr_rdata = 32'd0;
      case (insn[31:20])
         CSR_MSTATUS: csr_rdata = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
         CSR_MIE:     csr_rdata = csr_mie_q;
         CSR_MTVEC:   csr_rdata = {mtvec_q, 2'b00};
         CSR_MEPC:    csr_rdata = {mepc_q, 2'b00};
         CSR_MCAUSE:  csr_rdata = mcause_q;
         default:     ;
      endcase
      csr_src   = f3[2] ? {27'b0, rs1_a} : rs1_v;
      csr_wdata = csr_rdata;
      case (f3[1:0])
         2'b01:   csr_wdata = csr_src;
         2'b10:   csr_wdata = csr_rdata | csr_src;
         2'b11:   csr_wdata = csr_rdata & ~csr_src;
         default: ;
      endcase
   end

   always_comb begin
      pc_d           = pc_plus4;
      rd_we          = 1'b0;
      rd_val         = alu_res;
      dmem_re        = 1'b0;
      dmem_we        = 1'b0;
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      csr_mie_d      = csr_mie_q;
      mtvec_d        = mtvec_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      // A taken interrupt replaces the fetched instruction entirely
      if (irq_take) begin
         mepc_d                    = pc_q[31:2];
         mcause_d                  = 32'(irq_num);
         mcause_d[MCAUSE_INTR_BIT] = 1'b1;
         mstatus_mpie_d            = mstatus_mie_q;
         mstatus_mie_d             = 1'b0;
         pc_d                      = {mtvec_q, 2'b00};
      end else begin
         case (opcode)
            OP_LUI, OP_AUIPC: rd_we = 1'b1;
            OP_JAL:    begin rd_we = 1'b1; rd_val = pc_plus4; pc_d = pc_q + imm_j; end
            OP_JALR:   if (f3 == 3'b000) begin
                          rd_we = 1'b1; rd_val = pc_plus4; pc_d = (rs1_v + imm_i) & ~32'd1;
                       end
            OP_BRANCH: if (br_take) pc_d = pc_q + imm_b;
            OP_LOAD:   if (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU) begin
                          dmem_re = 1'b1; rd_we = 1'b1; rd_val = ld_val;
                       end
            OP_STORE:  dmem_we = (f3 == F3_B || f3 == F3_H || f3 == F3_W);
            OP_IMM:    rd_we = legal_imm;
            OP_REG:    rd_we = legal_reg;
            OP_SYSTEM: begin
               if (insn == INSN_MRET) begin
                  pc_d           = {mepc_q, 2'b00};
                  mstatus_mie_d  = mstatus_mpie_q;
                  mstatus_mpie_d = 1'b1;
               end else if (f3 != F3_PRIV && f3 != 3'b100) begin
                  rd_we  = 1'b1;
                  rd_val = csr_rdata;
                  if (f3[1:0] == 2'b01 || rs1_a != 5'd0) begin
                     case (insn[31:20])
                        CSR_MSTATUS: begin mstatus_mie_d = csr_wdata[3]; mstatus_mpie_d = csr_wdata[7]; end
                        CSR_MIE:     csr_mie_d = csr_wdata;
                        CSR_MTVEC:   mtvec_d   = csr_wdata[31:2];
                        CSR_MEPC:    mepc_d    = csr_wdata[31:2];
                        CSR_MCAUSE:  mcause_d  = csr_wdata;
                        default:     ;
                     endcase
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pc_q           <= RESET_VEC;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         csr_mie_q      <= '0;
         mtvec_q        <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         for (int i = 1; i < 32; i++) rf_q[i] <= '0;
      end else begin
         pc_q           <= pc_d;
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         csr_mie_q      <= csr_mie_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         if (rd_we && rd_a != 5'd0) rf_q[rd_a] <= rd_val;
      end
   end

   // Memory strobes are forced quiet while reset is held, even mid-store
   assign o_imem_addr   = pc_q;
   assign o_dmem_re     = i_rst & dmem_re;
   assign o_dmem_we     = i_rst & dmem_we;
   assign o_dmem_sel    = (i_rst && (dmem_re || dmem_we)) ? lane_sel : 4'h0;
   assign o_dmem_addr   = i_rst ? ea : 32'd0;
   assign o_dmem_w_data = i_rst ? st_data : 32'd0;

`ifdef OTTER_RVFI_EN
   assign rvfi_valid     = i_rst & ~irq_take;
   assign rvfi_insn      = insn;
   assign rvfi_pc_rdata  = pc_q;
   assign rvfi_pc_wdata  = pc_d;
   assign rvfi_rd_addr   = (rd_we && rd_a != 5'd0) ? rd_a : 5'd0;
   assign rvfi_rd_wdata  = (rd_we && rd_a != 5'd0) ? rd_val : 32'd0;
   assign rvfi_mem_addr  = o_dmem_addr;
   assign rvfi_mem_rmask = o_dmem_re ? o_dmem_sel : 4'h0;
   assign rvfi_mem_wmask = o_dmem_we ? o_dmem_sel : 4'h0;
   assign rvfi_mem_wdata = o_dmem_w_data;
`endif
endmodule

// File: tb/tb_otter_mcu_core.sv
// Table-driven bench for otter_mcu_core: one instruction per record, expected
// PC and data-memory strobes queued at drive time and compared mid-cycle.
module tb_otter_mcu_core;
   localparam logic [6:0] OPI = 7'h13, LOAD = 7'h03, LUI = 7'h37, JALR = 7'h67;

   typedef struct {
      logic [31:0] insn, rdata, intr, pc;
      logic        re, we;
      logic [3:0]  sel;
      logic [31:0] addr, wdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_intrpt, i_imem_r_data, i_dmem_r_data;
   logic [31:0] o_imem_addr, o_dmem_addr, o_dmem_w_data;
   logic        o_dmem_re, o_dmem_we;
   logic [3:0]  o_dmem_sel;

   vec_t        tbl[$];
   vec_t        sb[$];
   vec_t        hv;
   logic [31:0] fill_pc;
   int          n_cmp = 0;
   int          n_fail = 0;

   otter_mcu_core dut (
      .i_clk(clk), .i_rst(i_rst), .i_intrpt(i_intrpt),
      .i_imem_r_data(i_imem_r_data), .o_imem_addr(o_imem_addr),
      .i_dmem_r_data(i_dmem_r_data), .o_dmem_re(o_dmem_re), .o_dmem_we(o_dmem_we),
      .o_dmem_sel(o_dmem_sel), .o_dmem_addr(o_dmem_addr), .o_dmem_w_data(o_dmem_w_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] j_t(int imm, int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
   endfunction
   function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] csr_t(int csr, int rs1, int f3, int rd);
      return {csr[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'h73};
   endfunction

   task automatic add(input logic [31:0] insn, rdata, intr, input logic re, we,
                      input logic [3:0] sel, input logic [31:0] addr, wdata, nxt);
      vec_t v;
      v.insn = insn; v.rdata = rdata; v.intr = intr; v.pc = fill_pc;
      v.re = re; v.we = we; v.sel = sel; v.addr = addr; v.wdata = wdata;
      tbl.push_back(v);
      fill_pc = nxt;
   endtask
   task automatic op(input logic [31:0] insn);
      add(insn, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, fill_pc + 32'd4);
   endtask
   task automatic jmp(input logic [31:0] insn, input logic [31:0] target);
      add(insn, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, target);
   endtask
   task automatic sw(input int rs2, input int imm, input logic [31:0] wdata);
      add(s_t(imm, rs2, 0, 2), 32'h0, 32'h0, 1'b0, 1'b1, 4'hF, imm, wdata, fill_pc + 32'd4);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Entered and left at posedge+1; compares at the falling edge
   task automatic apply(input vec_t v);
      vec_t e;
      i_imem_r_data = v.insn;
      i_dmem_r_data = v.rdata;
      i_intrpt      = v.intr;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("pc@%h", e.pc), o_imem_addr, e.pc);
      check($sformatf("re@%h", e.pc), {31'b0, o_dmem_re}, {31'b0, e.re});
      check($sformatf("we@%h", e.pc), {31'b0, o_dmem_we}, {31'b0, e.we});
      check($sformatf("sel@%h", e.pc), {28'b0, o_dmem_sel}, {28'b0, e.sel});
      if (e.re || e.we) check($sformatf("addr@%h", e.pc), o_dmem_addr, e.addr);
      if (e.we) check($sformatf("wdata@%h", e.pc), o_dmem_w_data, e.wdata);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_imem"}, o_imem_addr, 32'h0);
      check({tag, "_re"}, {31'b0, o_dmem_re}, 32'h0);
      check({tag, "_we"}, {31'b0, o_dmem_we}, 32'h0);
      check({tag, "_sel"}, {28'b0, o_dmem_sel}, 32'h0);
      check({tag, "_addr"}, o_dmem_addr, 32'h0);
      check({tag, "_wdata"}, o_dmem_w_data, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      fill_pc = 32'h0;
      repeat (6) op(32'h82f7b013);
      sw(0, 4, 32'h0);
      op(i_t(-1, 0, 0, 1, OPI));
      op(i_t(1, 0, 3, 2, OPI));
      op(i_t(5, 1, 3, 3, OPI));
      sw(1, 0, 32'hFFFFFFFF);
      sw(2, 8, 32'h1);
      sw(3, 12, 32'h0);
      add(s_t(3, 1, 0, 0), 32'h0, 32'h0, 1'b0, 1'b1, 4'b1000, 32'd3, 32'hFF000000, fill_pc + 32'd4);
      add(s_t(2, 1, 0, 1), 32'h0, 32'h0, 1'b0, 1'b1, 4'b1100, 32'd2, 32'hFFFF0000, fill_pc + 32'd4);
      add(i_t(3, 0, 0, 4, LOAD), 32'h80123456, 32'h0, 1'b1, 1'b0, 4'b1000, 32'd3, 32'h0, fill_pc + 32'd4);
      add(i_t(3, 0, 4, 5, LOAD), 32'h80123456, 32'h0, 1'b1, 1'b0, 4'b1000, 32'd3, 32'h0, fill_pc + 32'd4);
      sw(4, 16, 32'hFFFFFF80);
      sw(5, 20, 32'h00000080);
      add(i_t(2, 0, 1, 6, LOAD), 32'h80017F00, 32'h0, 1'b1, 1'b0, 4'b1100, 32'd2, 32'h0, fill_pc + 32'd4);
      sw(6, 24, 32'hFFFF8001);
      op(i_t(5, 0, 0, 7, OPI));
      op(r_t(32, 1, 7, 0, 8));
      op({20'h80000, 5'd10, LUI});
      op(i_t(1028, 10, 5, 11, OPI));
      op(i_t(4, 10, 5, 12, OPI));
      op(r_t(0, 7, 10, 2, 13));
      op(r_t(0, 7, 10, 3, 14));
      sw(8, 28, 32'd6);
      sw(11, 32, 32'hF8000000);
      sw(12, 36, 32'h08000000);
      sw(13, 40, 32'd1);
      sw(14, 44, 32'd0);
      jmp(b_t(16, 0, 0, 0), fill_pc + 32'd16);
      op(b_t(16, 0, 0, 1));
      jmp(b_t(8, 7, 10, 4), fill_pc + 32'd8);
      op(b_t(8, 7, 10, 6));
      jmp(j_t(12, 15), fill_pc + 32'd12);
      op(i_t(256, 0, 0, 16, OPI));
      jmp(i_t(1, 16, 0, 1, JALR), 32'h100);
      sw(1, 48, 32'd184);
      sw(15, 52, 32'd168);
      op(i_t(512, 0, 0, 17, OPI));
      op(csr_t(12'h305, 17, 1, 0));
      op(i_t(12, 0, 0, 18, OPI));
      op(csr_t(12'h304, 18, 1, 0));
      add(s_t(56, 18, 0, 2), 32'h0, 32'h4, 1'b0, 1'b1, 4'hF, 32'd56, 32'd12, fill_pc + 32'd4);
      op(csr_t(12'h300, 8, 6, 19));
      add(s_t(60, 19, 0, 2), 32'h0, 32'h10, 1'b0, 1'b1, 4'hF, 32'd60, 32'd0, fill_pc + 32'd4);
      op(i_t(64, 0, 0, 20, OPI));
      jmp(i_t(0, 20, 0, 0, JALR), 32'h40);
      add(s_t(0, 1, 0, 2), 32'h0, 32'hC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h200);
      op(csr_t(12'h341, 0, 2, 21));
      op(csr_t(12'h342, 0, 2, 22));
      op(csr_t(12'h300, 0, 2, 23));
      sw(21, 64, 32'h40);
      sw(22, 68, 32'h80000002);
      sw(23, 72, 32'h80);
      jmp(32'h30200073, 32'h40);
      op(csr_t(12'h300, 0, 2, 24));
      sw(24, 76, 32'h88);
      op(csr_t(12'h305, 0, 1, 25));
      sw(25, 80, 32'h200);
      op(32'h00000073);
      op(32'hFFFFFFFF);
      op(32'h0000000F);

      i_rst = 1'b0;
      i_intrpt = 32'h0;
      i_dmem_r_data = 32'h0;
      i_imem_r_data = s_t(12, 0, 0, 2);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("in_reset");
      repeat (2) @(posedge clk);
      #1;
      check("in_reset_pc_hold", o_imem_addr, 32'h0);
      i_rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      i_imem_r_data = s_t(0, 1, 0, 2);
      i_intrpt = 32'h0;
      @(negedge clk);
      check("mid_sw_pc", o_imem_addr, fill_pc);
      check("mid_sw_we", {31'b0, o_dmem_we}, 32'h1);
      #1;
      i_rst = 1'b0;
      #1;
      check_reset_outputs("mid_sw_reset");
      @(posedge clk);
      #1;
      i_rst = 1'b1;
      hv.insn = s_t(0, 1, 0, 2); hv.rdata = 32'h0; hv.intr = 32'h0; hv.pc = 32'h0;
      hv.re = 1'b0; hv.we = 1'b1; hv.sel = 4'hF; hv.addr = 32'h0; hv.wdata = 32'h0;
      apply(hv);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
